thread_out_fifo: RTL and testbench

Per-thread output packet buffer between one processor thread's packet-write port and the output FIFO arbiter. Stores complete packets written by the thread and raises a one-cycle `thread_done` pulse per buffered packet. On the arbiter's `start_read` pulse it drains exactly one packet as a contiguous burst of `df_out_wr`-qualified words. One instance per thread; NUM_THREADS instances feed the arbiter's concatenated `df_out_*` buses.

---
 rtl/arya_pkt_pkg.sv | 14 +
 rtl/sdp_ram.sv | 29 ++
 rtl/thread_out_fifo.sv | 151 +++++++++++++++
 tb/tb_thread_out_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arya_pkt_pkg.sv
// Shared packet-path definitions: word widths and the per-thread output FIFO
// control states.
package arya_pkt_pkg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NOTIFY = 2'd1,
        DRAIN  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one synchronous read port on the
// same clock. A read of the address being written returns the old contents.
module sdp_ram #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 73
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W) - 1];

    // NOTE: the array and read register have no reset so they map onto block
    // RAM; the top only consumes rd_data when it has marked it valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/thread_out_fifo.sv
// Per-thread output packet buffer: stores complete packets from one thread,
// announces each with thread_done and drains one packet per start_read.
module thread_out_fifo #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = arya_pkt_pkg::DATA_W,
    parameter int CTRL_W = arya_pkt_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_last,
    input  logic              in_wr,
    output logic              in_rdy,
    output logic              thread_done,
    input  logic              start_read,
    output logic [DATA_W-1:0] df_out_data,
    output logic [CTRL_W-1:0] df_out_ctrl,
    output logic              df_out_wr,
    output logic              overflow
);
    import arya_pkt_pkg::*;

    localparam int WORD_W = DATA_W + CTRL_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    fifo_state_t       state, state_next;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, fetch_addr;
    logic [ADDR_W:0]   word_count, pkt_count;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic              push, fetch, commit, rd_valid, rd_last, done_set;

    assign in_rdy  = (word_count != FULL_COUNT);
    assign push    = in_wr && in_rdy;
    assign wr_word = {in_last, in_ctrl, in_data};
    assign rd_last = rd_word[WORD_W-1];

    // Reads are speculative: a fetched word only leaves the buffer (commit)
    // once its last bit is visible, so the drain never runs past a packet.
    assign commit     = (state == DRAIN) && rd_valid;
    assign fetch_addr = rd_ptr + ADDR_W'(rd_valid);

    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the block can infer a latch.
    always_comb begin
        fetch = 1'b0;
        if ((state == DRAIN) || ((state == NOTIFY) && start_read)) begin
            fetch = (word_count > {{ADDR_W{1'b0}}, rd_valid}) && !(commit && rd_last);
        end
    end

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_count != '0) begin
                    done_set   = 1'b1;
                    state_next = NOTIFY;
                end
            end
            NOTIFY: begin
                if (start_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (commit && rd_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            thread_done <= 1'b0;
        end else begin
            state       <= state_next;
            thread_done <= done_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_count <= '0;
            pkt_count  <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rd_valid <= fetch;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, commit})
                2'b10:   word_count <= word_count + CNT_ONE;
                2'b01:   word_count <= word_count - CNT_ONE;
                default: ;
            endcase
            case ({push && in_last, commit && rd_last})
                2'b10:   pkt_count <= pkt_count + CNT_ONE;
                2'b01:   pkt_count <= pkt_count - CNT_ONE;
                default: ;
            endcase
            if (in_wr && !in_rdy) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            df_out_wr   <= 1'b0;
            df_out_data <= '0;
            df_out_ctrl <= '0;
        end else begin
            df_out_wr <= commit;
            if (commit) begin
                df_out_data <= rd_word[DATA_W-1:0];
                df_out_ctrl <= rd_word[DATA_W +: CTRL_W];
            end
        end
    end

    sdp_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_en   (fetch),
        .rd_addr (fetch_addr),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_thread_out_fifo.sv
// Scoreboard bench for thread_out_fifo: writes push expected words into a
// queue, an independent monitor pops and compares every df_out_wr word.
module tb_thread_out_fifo;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_last;
    logic              in_wr;
    logic              in_rdy;
    logic              thread_done;
    logic              start_read;
    logic [DATA_W-1:0] df_out_data;
    logic [CTRL_W-1:0] df_out_ctrl;
    logic              df_out_wr;
    logic              overflow;

    always #5 clk = ~clk;

    thread_out_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_last     (in_last),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .thread_done (thread_done),
        .start_read  (start_read),
        .df_out_data (df_out_data),
        .df_out_ctrl (df_out_ctrl),
        .df_out_wr   (df_out_wr),
        .overflow    (overflow)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } word_t;

    word_t exp_q[$];
    word_t mon_w;
    int    total    = 0;
    int    bad      = 0;
    int    done_cnt = 0;

    logic [DATA_W-1:0] t1_data [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [CTRL_W-1:0] t1_ctrl [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts thread_done pulses and scores every drained word.
    always @(negedge clk) begin
        if (thread_done) begin
            done_cnt++;
        end
        if (df_out_wr) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra: got %0h/%0h expected no word at %0t",
                         df_out_data, df_out_ctrl, $time);
            end else begin
                mon_w = exp_q.pop_front();
                check("out_data", df_out_data, mon_w.data);
                check("out_ctrl", 64'(df_out_ctrl), 64'(mon_w.ctrl));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input logic [15:0] tag, input int i);
        return {tag, 16'(i), 32'(i) ^ 32'h5A5A_C3C3};
    endfunction

    task automatic put(input logic [63:0] d, input logic [7:0] c, input logic l);
        in_data = d;
        in_ctrl = c;
        in_last = l;
        in_wr   = 1'b1;
        exp_q.push_back('{d, c});
        tick();
        in_wr   = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic put_pkt(input int n, input logic [15:0] tag);
        for (int i = 0; i < n; i++) begin
            put(pat(tag, i), 8'(i), i == n - 1);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            tick();
        end
        check("done_count", 64'(done_cnt), 64'(target));
    endtask

    // One start_read pulse, then exactly n consecutive df_out_wr cycles
    // beginning two cycles after the pulse, then a low cycle.
    task automatic drain(input int n);
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        check("drain_latency_gap", 64'(df_out_wr), 64'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            check("drain_burst", 64'(df_out_wr), 64'd1);
        end
        tick();
        check("drain_end", 64'(df_out_wr), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_ctrl    = '0;
        in_last    = 1'b0;
        in_wr      = 1'b0;
        start_read = 1'b0;
        repeat (3) tick();
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_thread_done", 64'(thread_done), 64'd0);
        check("rst_df_out_wr", 64'(df_out_wr), 64'd0);
        check("rst_df_out_data", df_out_data, 64'd0);
        check("rst_df_out_ctrl", 64'(df_out_ctrl), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();

        // Single 4-word packet; thread_done is a single pulse.
        for (int i = 0; i < 4; i++) begin
            put(t1_data[i], t1_ctrl[i], i == 3);
        end
        check("t1_done_not_yet", 64'(thread_done), 64'd0);
        tick();
        check("t1_done_pulse", 64'(thread_done), 64'd1);
        tick();
        check("t1_done_single", 64'(thread_done), 64'd0);
        repeat (8) tick();
        drain(4);
        check("t1_done_total", 64'(done_cnt), 64'd1);

        // Two buffered packets: one announcement at a time.
        put_pkt(3, 16'h2222);
        put_pkt(3, 16'h3333);
        repeat (5) tick();
        check("t2_one_done", 64'(done_cnt), 64'd2);
        drain(3);
        wait_done(3, 10);
        drain(3);
        repeat (5) tick();
        check("t2_no_extra_done", 64'(done_cnt), 64'd3);

        // Full buffer, dropped 257th write, sticky overflow.
        put_pkt(256, 16'h4444);
        check("t3_full_rdy", 64'(in_rdy), 64'd0);
        check("t3_no_overflow_yet", 64'(overflow), 64'd0);
        in_data = 64'hDEAD_DEAD_DEAD_DEAD;
        in_ctrl = 8'hEE;
        in_last = 1'b1;
        in_wr   = 1'b1;
        tick();
        in_wr   = 1'b0;
        in_last = 1'b0;
        check("t3_overflow_set", 64'(overflow), 64'd1);
        check("t3_still_full", 64'(in_rdy), 64'd0);
        wait_done(4, 10);
        drain(256);
        check("t3_rdy_after_drain", 64'(in_rdy), 64'd1);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);
        put_pkt(225, 16'h5555);
        wait_done(5, 10);
        drain(225);

        // start_read with nothing announced must be ignored.
        repeat (3) tick();
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_spurious_no_wr", 64'(df_out_wr), 64'd0);
        end
        check("t4_spurious_no_done", 64'(done_cnt), 64'd5);
        put_pkt(2, 16'h6666);
        wait_done(6, 10);
        drain(2);

        // Packet spanning address 255->0 drained while the next one is written.
        put_pkt(25, 16'h7777);
        wait_done(7, 10);
        fork
            drain(25);
            begin
                tick();
                for (int i = 0; i < 20; i++) begin
                    check("t5_rdy_concurrent", 64'(in_rdy), 64'd1);
                    put(pat(16'h8888, i), 8'(i), i == 19);
                end
            end
        join
        wait_done(8, 10);
        drain(20);
        repeat (5) tick();
        check("t5_no_extra_done", 64'(done_cnt), 64'd8);
        check("t5_rdy_idle", 64'(in_rdy), 64'd1);

        // Reset after three words of an 8-word drain discards everything.
        put_pkt(8, 16'h9999);
        wait_done(9, 10);
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_partial_burst", 64'(df_out_wr), 64'd1);
        end
        reset = 1'b1;
        tick();
        check("t6_rst_df_out_wr", 64'(df_out_wr), 64'd0);
        check("t6_rst_in_rdy", 64'(in_rdy), 64'd1);
        check("t6_rst_thread_done", 64'(thread_done), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        repeat (6) tick();
        check("t6_empty_no_done", 64'(done_cnt), 64'd9);
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_empty_no_wr", 64'(df_out_wr), 64'd0);
        end
        put_pkt(3, 16'hAAAA);
        wait_done(10, 10);
        drain(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
